// File: rtl/lutram_bist_ctrl.sv
// lutram_bist_ctrl: write-all/read-all BIST sequencer for the LUTRAM stress array.
// Each pass writes an address-derived pattern to every word and then reads it back.
// Odd passes invert the pattern. The block reports a sticky fail flag, a saturating
// error count and the address of the first mismatch of the run.
module lutram_bist_ctrl #(
  parameter int unsigned LUTRAM16X10 = 265,
  parameter int unsigned PASSES      = 2,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [9:0]  SEED        = 10'h000,
  localparam int unsigned DEPTH      = LUTRAM16X10 * 16,
  localparam int unsigned ADDR_W     = $clog2(LUTRAM16X10 * 16)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [9:0]        mem_wdat,
  input  logic [9:0]        mem_rdat,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int unsigned PASS_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned PIPE_N  = (RD_LAT > 0) ? RD_LAT : 1;
  localparam int unsigned OUT_IDX = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addrCnt_q, addrCnt_d;
  logic [PASS_W-1:0]   passCnt_q, passCnt_d;
  logic [1:0]          drainCnt_q, drainCnt_d;
  logic                memWe_q, memWe_d;
  logic [9:0]          memWdat_q, memWdat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [15:0]         errCnt_q, errCnt_d;
  logic [ADDR_W-1:0]   errAddr_q, errAddr_d;

  logic                pipeValid_q [PIPE_N];
  logic [ADDR_W-1:0]   pipeAddr_q  [PIPE_N];
  logic [9:0]          pipeExp_q   [PIPE_N];

  logic                issueValid;
  logic [9:0]          issueExp;
  logic                cmpValid;
  logic [ADDR_W-1:0]   cmpAddr;
  logic [9:0]          cmpExp;
  logic                lastAddr;
  logic                lastPass;
  logic                lastDrain;

  // Pattern word: address folded into 10 bits, seeded, inverted on odd passes.
  function automatic logic [9:0] pattern(input logic [ADDR_W-1:0] a, input logic p0);
    return 10'(a) ^ SEED ^ {10{p0}};
  endfunction

  // Read issue and compare-point selection; RD_LAT=0 compares the issue directly.
  always_comb begin
    issueValid = (state_q == READ) && !abort;
    issueExp   = pattern(addrCnt_q, passCnt_q[0]);
    if (RD_LAT == 0) begin
      cmpValid = issueValid;
      cmpAddr  = addrCnt_q;
      cmpExp   = issueExp;
    end else begin
      cmpValid = pipeValid_q[OUT_IDX] && !abort;
      cmpAddr  = pipeAddr_q[OUT_IDX];
      cmpExp   = pipeExp_q[OUT_IDX];
    end
    lastAddr  = (addrCnt_q == ADDR_W'(DEPTH - 1));
    lastPass  = (passCnt_q == PASS_W'(PASSES - 1));
    lastDrain = (32'(drainCnt_q) == RD_LAT - 1);
  end

  // Sequencer next state, counters, status and registered output values.
  always_comb begin
    state_d    = state_q;
    addrCnt_d  = addrCnt_q;
    passCnt_d  = passCnt_q;
    drainCnt_d = drainCnt_q;
    fail_d     = fail_q;
    errCnt_d   = errCnt_q;
    errAddr_d  = errAddr_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = WRITE;
          addrCnt_d = '0;
          passCnt_d = '0;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d   = IDLE;
          addrCnt_d = '0;
        end else if (lastAddr) begin
          state_d   = READ;
          addrCnt_d = '0;
        end else begin
          addrCnt_d = addrCnt_q + 1'b1;
        end
      end
      READ: begin
        if (abort) begin
          state_d   = IDLE;
          addrCnt_d = '0;
        end else if (lastAddr) begin
          addrCnt_d  = '0;
          drainCnt_d = '0;
          if (RD_LAT != 0) begin
            state_d = DRAIN;
          end else if (lastPass) begin
            state_d = DONE;
          end else begin
            state_d   = WRITE;
            passCnt_d = passCnt_q + 1'b1;
          end
        end else begin
          addrCnt_d = addrCnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (lastDrain) begin
          drainCnt_d = '0;
          if (lastPass) begin
            state_d = DONE;
          end else begin
            state_d   = WRITE;
            passCnt_d = passCnt_q + 1'b1;
          end
        end else begin
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q == IDLE && start && !abort) begin
      fail_d    = 1'b0;
      errCnt_d  = '0;
      errAddr_d = '0;
    end else if (cmpValid && (mem_rdat != cmpExp)) begin
      fail_d = 1'b1;
      if (errCnt_q != 16'hFFFF) begin
        errCnt_d = errCnt_q + 16'd1;
      end
      if (!fail_q) begin
        errAddr_d = cmpAddr;
      end
    end

    memWe_d   = (state_d == WRITE);
    memWdat_d = (state_d == WRITE) ? pattern(addrCnt_d, passCnt_d[0]) : 10'h000;
    busy_d    = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
  end

  // State, counters, status and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addrCnt_q  <= '0;
      passCnt_q  <= '0;
      drainCnt_q <= '0;
      memWe_q    <= 1'b0;
      memWdat_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      errCnt_q   <= '0;
      errAddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      addrCnt_q  <= addrCnt_d;
      passCnt_q  <= passCnt_d;
      drainCnt_q <= drainCnt_d;
      memWe_q    <= memWe_d;
      memWdat_q  <= memWdat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      errCnt_q   <= errCnt_d;
      errAddr_q  <= errAddr_d;
    end
  end

  // Expected-data pipe matching the array read latency; abort flushes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_N; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeAddr_q[i]  <= '0;
        pipeExp_q[i]   <= '0;
      end
    end else begin
      pipeValid_q[0] <= issueValid;
      pipeAddr_q[0]  <= addrCnt_q;
      pipeExp_q[0]   <= issueExp;
      for (int i = 1; i < PIPE_N; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1] && !abort;
        pipeAddr_q[i]  <= pipeAddr_q[i-1];
        pipeExp_q[i]   <= pipeExp_q[i-1];
      end
    end
  end

  assign mem_addr = addrCnt_q;
  assign mem_we   = memWe_q;
  assign mem_wdat = memWdat_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign err_cnt  = errCnt_q;
  assign err_addr = errAddr_q;

endmodule

// File: tb/tb_lutram_bist_ctrl.sv
// tb_lutram_bist_ctrl: scoreboard bench for the LUTRAM BIST sequencer with a
// faultable synchronous-read memory model and a run-level reference model.
module tb_lutram_bist_ctrl;

  localparam int NB     = 2;
  localparam int DEPTH  = NB * 16;
  localparam int AW     = 5;
  localparam int PASSES = 2;
  localparam int RD_LAT = 1;
  localparam logic [9:0] SEED = 10'h000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [9:0]    mem_wdat;
  logic [9:0]    mem_rdat;
  logic          busy;
  logic          done;
  logic          fail;
  logic [15:0]   err_cnt;
  logic [AW-1:0] err_addr;

  typedef struct {
    int          cycles;
    logic        fail;
    logic [15:0] errCnt;
    logic [AW-1:0] errAddr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int   faultMode = 0;
  int   faultAddr = 0;
  int   faultBit  = 0;
  logic faultVal  = 1'b0;

  logic [9:0] mem [DEPTH];

  lutram_bist_ctrl #(
    .LUTRAM16X10(NB),
    .PASSES     (PASSES),
    .RD_LAT     (RD_LAT),
    .SEED       (SEED)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mem_addr(mem_addr),
    .mem_we  (mem_we),
    .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat),
    .busy    (busy),
    .done    (done),
    .fail    (fail),
    .err_cnt (err_cnt),
    .err_addr(err_addr)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Read-side fault injection applied on top of the stored word.
  function automatic logic [9:0] readFault(input int a, input logic [9:0] d);
    logic [9:0] r;
    r = d;
    if (faultMode == 1 && a == faultAddr) r[faultBit] = faultVal;
    if (faultMode == 2) r = 10'h000;
    return r;
  endfunction

  // Array model: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdat;
    mem_rdat <= readFault(int'(mem_addr), mem[mem_addr]);
  end

  // Whole-run expectation: every pass reads back every word through the fault model.
  function automatic exp_t refRun();
    exp_t e;
    logic [9:0] expW;
    logic [9:0] got;
    e.cycles  = PASSES * (2 * DEPTH + RD_LAT);
    e.fail    = 1'b0;
    e.errCnt  = 16'd0;
    e.errAddr = '0;
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        expW = 10'(a) ^ SEED ^ (((p % 2) == 1) ? 10'h3FF : 10'h000);
        got  = readFault(a, expW);
        if (got != expW) begin
          if (!e.fail) e.errAddr = AW'(a);
          e.fail = 1'b1;
          if (e.errCnt != 16'hFFFF) e.errCnt = e.errCnt + 16'd1;
        end
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit doStart, input bit doAbort, input bit expectRun);
    @(negedge clk);
    start = doStart;
    abort = doAbort;
    if (expectRun) sb.push_back(refRun());
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  int   busyCnt  = 0;
  int   writeIdx = 0;
  logic prevBusy = 1'b0;

  // Monitor: checks the write stream and pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    int   wa;
    int   wp;
    logic [9:0] wexp;
    if (rst) begin
      busyCnt  = 0;
      writeIdx = 0;
      prevBusy = 1'b0;
    end else begin
      if (busy && !prevBusy) writeIdx = 0;
      if (mem_we) begin
        wa   = writeIdx % DEPTH;
        wp   = writeIdx / DEPTH;
        wexp = 10'(wa) ^ SEED ^ (((wp % 2) == 1) ? 10'h3FF : 10'h000);
        checkOutput("wr_addr", 32'(mem_addr), 32'(wa));
        checkOutput("wr_dat", 32'(mem_wdat), 32'(wexp));
        writeIdx++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("busy_cycles", 32'(busyCnt), 32'(e.cycles));
          checkOutput("fail", 32'(fail), 32'(e.fail));
          checkOutput("err_cnt", 32'(err_cnt), 32'(e.errCnt));
          checkOutput("err_addr", 32'(err_addr), 32'(e.errAddr));
        end
        busyCnt = 0;
      end else if (busy) begin
        busyCnt++;
      end else begin
        busyCnt = 0;
      end
      prevBusy = busy;
    end
  end

  // Directed scenarios followed by randomized fault runs.
  initial begin
    exp_t held;
    int   n;
    int   doneSeen;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_wdat", 32'(mem_wdat), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_fail", 32'(fail), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_err_addr", 32'(err_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run.
    faultMode = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitIdle(400);

    // Bit 3 of word 5 stuck at 0.
    faultMode = 1; faultAddr = 5; faultBit = 3; faultVal = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitIdle(400);

    // Every read returns zero.
    faultMode = 2;
    held = refRun();
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitIdle(400);

    // start together with abort in IDLE must leave status untouched.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("sa_busy", 32'(busy), 32'd0);
    checkOutput("sa_we", 32'(mem_we), 32'd0);
    checkOutput("sa_fail", 32'(fail), 32'(held.fail));
    checkOutput("sa_err_cnt", 32'(err_cnt), 32'(held.errCnt));
    checkOutput("sa_err_addr", 32'(err_addr), 32'(held.errAddr));

    // Abort in READ at address 10.
    faultMode = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(busy && !mem_we && mem_addr == AW'(10)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reach", 32'(n < 200), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_we", 32'(mem_we), 32'd0);
    checkOutput("abort_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("abort_fail", 32'(fail), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);

    // Full run after the abort, with start re-pulsed mid-run.
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle(400);

    // Randomized stuck-bit runs.
    for (int r = 0; r < 6; r++) begin
      faultMode = int'($urandom_range(0, 1));
      faultAddr = int'($urandom_range(0, DEPTH - 1));
      faultBit  = int'($urandom_range(0, 9));
      faultVal  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 100)) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
      end
      waitIdle(400);
    end

    // Asynchronous reset in the second-pass WRITE phase after first-pass errors.
    faultMode = 2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (75) @(negedge clk);
    checkOutput("pre_rst_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_we", 32'(mem_we), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_addr", 32'(mem_addr), 32'd0);
    checkOutput("arst_wdat", 32'(mem_wdat), 32'd0);
    checkOutput("arst_fail", 32'(fail), 32'd0);
    checkOutput("arst_err_cnt", 32'(err_cnt), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run after reset.
    faultMode = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitIdle(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
